// File: rtl/niosii_system_sysid_checker_pkg.sv
// ---------------------------------------------------------------------------
// Module : niosii_system_sysid_checker_pkg
// Brief  : Shared constants for the system-ID checker (states, addresses,
//          status bit positions, helpers).
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package niosii_system_sysid_checker_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD_ID  = 3'd1;
    localparam logic [2:0] ST_RD_TS  = 3'd2;
    localparam logic [2:0] ST_EVAL   = 3'd3;
    localparam logic [2:0] ST_RETRY  = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Bit positions used when the status is mirrored into a software register.
    localparam int STAT_BUSY    = 0;
    localparam int STAT_PASS    = 1;
    localparam int STAT_ID_MM   = 2;
    localparam int STAT_TS_MM   = 3;
    localparam int STAT_TIMEOUT = 4;

    function automatic logic [1:0] f_sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/niosii_system_sysid_checker_timeout.sv
// ---------------------------------------------------------------------------
// Module : niosii_system_sysid_checker_timeout
// Brief  : Loadable down counter; flags the cycle in which the last allowed
//          stall cycle is consumed.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module niosii_system_sysid_checker_timeout #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_expire = i_dec && !i_load && (r_cnt <= WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/niosii_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// Module : niosii_system_sysid_checker
// Brief  : Avalon-MM read master that fetches the system ID and build
//          timestamp, compares them and latches a sticky pass/fail status.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module niosii_system_sysid_checker
    import niosii_system_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h5705_D053,
    parameter bit          AUTO_START     = 1'b1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    output logic        o_avm_address,
    output logic        o_avm_read,
    input  logic        i_avm_waitrequest,
    input  logic [31:0] i_avm_readdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_id_mismatch,
    output logic        o_ts_mismatch,
    output logic        o_timeout,
    output logic [1:0]  o_retry_count,
    output logic [31:0] o_id_value,
    output logic [31:0] o_ts_value
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(MAX_RETRIES + 2);
    localparam logic [TW-1:0] c_to_load = TW'(TIMEOUT_CYCLES);
    localparam logic [AW-1:0] c_max_ret = AW'(MAX_RETRIES);

    logic [2:0]    r_state;
    logic          r_auto;
    logic          r_read;
    logic          r_addr;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic          r_id_mm;
    logic          r_ts_mm;
    logic          r_timeout;
    logic [1:0]    r_retry;
    logic [AW-1:0] r_attempts;
    logic [31:0]   r_id_value;
    logic [31:0]   r_ts_value;

    logic [2:0]    w_state_nxt;
    logic          w_accept;
    logic          w_stall;
    logic          w_expire;
    logic          w_launch;
    logic          w_can_retry;

    assign w_accept    = r_read && !i_avm_waitrequest;
    assign w_stall     = r_read && i_avm_waitrequest;
    assign w_launch    = i_start || r_auto;
    assign w_can_retry = (r_attempts < c_max_ret);

    // Reloaded on every non-stall cycle, so each read gets a fresh budget.
    niosii_system_sysid_checker_timeout #(
        .WIDTH (TW)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (!w_stall),
        .i_load_val (c_to_load),
        .i_dec      (w_stall),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_launch) w_state_nxt = ST_RD_ID;
            ST_RD_ID: begin
                if (w_accept)      w_state_nxt = ST_RD_TS;
                else if (w_expire) w_state_nxt = ST_RETRY;
            end
            ST_RD_TS: begin
                if (w_accept)      w_state_nxt = ST_EVAL;
                else if (w_expire) w_state_nxt = ST_RETRY;
            end
            ST_EVAL:   w_state_nxt = ST_FINISH;
            ST_RETRY:  w_state_nxt = w_can_retry ? ST_RD_ID : ST_FINISH;
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_auto     <= AUTO_START;
            r_read     <= 1'b0;
            r_addr     <= ADDR_ID;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_id_mm    <= 1'b0;
            r_ts_mm    <= 1'b0;
            r_timeout  <= 1'b0;
            r_retry    <= 2'd0;
            r_attempts <= '0;
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_auto  <= 1'b0;
            // Strobe/address derive from next state so they are flop outputs.
            r_read  <= (w_state_nxt == ST_RD_ID) || (w_state_nxt == ST_RD_TS);
            r_addr  <= (w_state_nxt == ST_RD_TS) ? ADDR_TS : ADDR_ID;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_FINISH);

            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_pass     <= 1'b0;
                        r_id_mm    <= 1'b0;
                        r_ts_mm    <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_retry    <= 2'd0;
                        r_attempts <= '0;
                    end
                end
                ST_RD_ID: if (w_accept) r_id_value <= i_avm_readdata;
                ST_RD_TS: if (w_accept) r_ts_value <= i_avm_readdata;
                ST_EVAL: begin
                    r_id_mm <= (r_id_value != EXPECTED_ID);
                    r_ts_mm <= (r_ts_value != EXPECTED_TS);
                    r_pass  <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);
                end
                ST_RETRY: begin
                    if (w_can_retry) begin
                        r_attempts <= r_attempts + AW'(1);
                        r_retry    <= f_sat_inc2(r_retry);
                    end else begin
                        r_timeout  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_avm_address = r_addr;
    assign o_avm_read    = r_read;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_id_mismatch = r_id_mm;
    assign o_ts_mismatch = r_ts_mm;
    assign o_timeout     = r_timeout;
    assign o_retry_count = r_retry;
    assign o_id_value    = r_id_value;
    assign o_ts_value    = r_ts_value;

endmodule

`default_nettype wire

// File: tb/tb_niosii_system_sysid_checker.sv
// ---------------------------------------------------------------------------
// Module : tb_niosii_system_sysid_checker
// Brief  : Directed self-checking bench with a stalling Avalon slave model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_niosii_system_sysid_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_mm, ts_mm, tmo;
    logic [1:0]  retry_count;
    logic [31:0] id_value, ts_value;

    logic [31:0] id_word;
    logic [31:0] ts_word;
    int stall_n  = 0;
    int wcnt     = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;
    int rise_cnt = 0;
    int viol     = 0;
    logic prev_stall = 1'b0;
    logic prev_addr  = 1'b0;
    logic prev_read  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    niosii_system_sysid_checker #(
        .EXPECTED_ID    (32'h0000_0000),
        .EXPECTED_TS    (32'h5705_D053),
        .AUTO_START     (1'b1),
        .TIMEOUT_CYCLES (4),
        .MAX_RETRIES    (3)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (start),
        .o_avm_address     (avm_address),
        .o_avm_read        (avm_read),
        .i_avm_waitrequest (avm_waitrequest),
        .i_avm_readdata    (avm_readdata),
        .o_busy            (busy),
        .o_done            (done),
        .o_pass            (pass),
        .o_id_mismatch     (id_mm),
        .o_ts_mismatch     (ts_mm),
        .o_timeout         (tmo),
        .o_retry_count     (retry_count),
        .o_id_value        (id_value),
        .o_ts_value        (ts_value)
    );

    // Slave model: stalls each read for stall_n cycles.
    assign avm_waitrequest = avm_read && (wcnt < stall_n);
    assign avm_readdata    = avm_address ? ts_word : id_word;

    always @(posedge clk) begin
        if (avm_read && avm_waitrequest) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
        if (done)                          done_cnt <= done_cnt + 1;
        if (avm_read && !avm_waitrequest)  acc_cnt  <= acc_cnt + 1;
        if (avm_read && !prev_read)        rise_cnt <= rise_cnt + 1;
        if (rst_n && prev_stall && (!avm_read || avm_address != prev_addr)) viol <= viol + 1;
        prev_stall <= avm_read && avm_waitrequest;
        prev_addr  <= avm_address;
        prev_read  <= avm_read;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic launch(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1, n);
    endtask

    int lat;
    int d0, a0, r0, v0;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        id_word = 32'h0000_0000;
        ts_word = 32'h5705_D053;
        stall_n = 0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy",  {31'd0, busy},     0);
        chk("rst_done",  {31'd0, done},     0);
        chk("rst_read",  {31'd0, avm_read}, 0);
        chk("rst_pass",  {31'd0, pass},     0);
        chk("rst_ts",    ts_value,          0);

        // Auto-start after reset release, matching words, no stalls
        rst_n = 1'b1;
        wait_done(0, lat);
        chk("auto_lat",   lat, 4);
        chk("auto_pass",  {31'd0, pass}, 1);
        chk("auto_id",    id_value, 32'h0000_0000);
        chk("auto_ts",    ts_value, 32'h5705_D053);
        chk("auto_busy",  {31'd0, busy}, 1);
        tick();
        chk("auto_done_drop", {31'd0, done}, 0);
        chk("auto_busy_drop", {31'd0, busy}, 0);

        // ID mismatch, no retry reads
        id_word = 32'h0000_0001;
        a0 = acc_cnt;
        launch(lat);
        chk("idmm_lat",   lat, 4);
        chk("idmm_flag",  {31'd0, id_mm}, 1);
        chk("idmm_ts",    {31'd0, ts_mm}, 0);
        chk("idmm_pass",  {31'd0, pass},  0);
        chk("idmm_retry", {30'd0, retry_count}, 0);
        chk("idmm_val",   id_value, 32'h0000_0001);
        tick();
        chk("idmm_reads", acc_cnt - a0, 2);

        // Three stall cycles on each read
        id_word = 32'h0000_0000;
        stall_n = 3;
        d0 = done_cnt;
        v0 = viol;
        launch(lat);
        chk("stall_lat",    lat, 10);
        chk("stall_pass",   {31'd0, pass}, 1);
        chk("stall_stable", viol - v0, 0);
        tick();
        chk("stall_ndone",  done_cnt - d0, 1);

        // Waitrequest stuck high: 4 attempts then timeout
        stall_n = 1000;
        d0 = done_cnt;
        a0 = acc_cnt;
        r0 = rise_cnt;
        launch(lat);
        chk("tmo_lat",    lat, 21);
        chk("tmo_flag",   {31'd0, tmo},  1);
        chk("tmo_retry",  {30'd0, retry_count}, 3);
        chk("tmo_pass",   {31'd0, pass}, 0);
        repeat (3) tick();
        chk("tmo_ndone",  done_cnt - d0, 1);
        chk("tmo_tries",  rise_cnt - r0, 4);
        chk("tmo_acc",    acc_cnt - a0, 0);
        chk("tmo_busy",   {31'd0, busy}, 0);

        // start while busy and in FINISH is ignored
        stall_n = 0;
        d0 = done_cnt;
        r0 = rise_cnt;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_done(2, lat);
        chk("busy_lat", lat, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("ign_ndone", done_cnt - d0, 1);
        chk("ign_tries", rise_cnt - r0, 1);
        chk("ign_busy",  {31'd0, busy}, 0);
        chk("ign_pass",  {31'd0, pass}, 1);

        // Reset asserted while the timestamp read is stalled
        stall_n = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!(avm_read && avm_address) && lat < 50) begin
            tick();
            lat++;
        end
        chk("mid_in_rdts", {31'd0, avm_read && avm_address}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_read", {31'd0, avm_read},    0);
        chk("mid_addr", {31'd0, avm_address}, 0);
        chk("mid_busy", {31'd0, busy},        0);
        chk("mid_ts",   ts_value,             0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_done(0, lat);
        chk("rerun_lat",  lat, 10);
        chk("rerun_pass", {31'd0, pass}, 1);
        chk("rerun_ts",   ts_value, 32'h5705_D053);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
